// File: rtl/serializador_dac.sv
// Output stage of the filter chain: scales a signed band sample to a 12-bit
// offset-binary code and ships it as a 16-bit SPI frame. Clamping behind SATURACION_EN.
module serializador_dac #(
    parameter int width = 22,
    parameter int shift = 8,
    parameter int DIV   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [width-1:0] dato_in,
    input  logic                    dato_listo,
    output logic                    sclk,
    output logic                    sync_n,
    output logic                    sdata,
    output logic                    ocupado,
    output logic                    fin_tx,
    output logic                    perdida,
    output logic                    saturo
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CARGA = 2'd1;
    localparam logic [1:0] TX    = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    localparam int            CW        = $clog2(2 * DIV + 1);
    localparam logic [CW-1:0] HALF_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] FIN_PULSE = CW'(2 * DIV - 2);
    localparam logic [CW-1:0] FIN_END   = CW'(2 * DIV - 1);

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    fase_q, fase_d;
    logic [3:0]              bits_q, bits_d;
    logic [15:0]             trama_q, trama_d;
    logic signed [width-1:0] muestra_q, muestra_d;
    logic sclk_q, sclk_d, sync_n_q, sync_n_d, sdata_q, sdata_d;
    logic ocupado_q, ocupado_d, fin_tx_q, fin_tx_d;
    logic perdida_q, perdida_d, saturo_q, saturo_d;

    logic signed [width-1:0] s;
    logic [11:0]             code;
    logic                    clip;
    logic [15:0]             trama_ini;

    assign s = muestra_q >>> shift;

`ifdef SATURACION_EN
    localparam logic signed [width-1:0] S_MAX = width'(2047);
    localparam logic signed [width-1:0] S_MIN = width'(-2048);

    always_comb begin
        clip = 1'b0;
        code = {~s[11], s[10:0]};
        if (s > S_MAX) begin
            code = 12'hFFF;
            clip = 1'b1;
        end else if (s < S_MIN) begin
            code = 12'h000;
            clip = 1'b1;
        end
    end
`else
    // Wrap-around: the upper bits of the shifted sample are simply discarded.
    logic unused_s;
    assign unused_s = ^s[width-1:12];
    assign code     = {~s[11], s[10:0]};
    assign clip     = 1'b0;
`endif

    assign trama_ini = {4'b0000, code};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fase_d    = fase_q;
        bits_d    = bits_q;
        trama_d   = trama_q;
        muestra_d = muestra_q;
        sclk_d    = sclk_q;
        sync_n_d  = sync_n_q;
        sdata_d   = sdata_q;
        ocupado_d = ocupado_q;
        fin_tx_d  = 1'b0;
        perdida_d = perdida_q;
        saturo_d  = saturo_q;

        if (dato_listo && state_q != IDLE) perdida_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (dato_listo) begin
                    muestra_d = dato_in;
                    ocupado_d = 1'b1;
                    state_d   = CARGA;
                end
            end
            CARGA: begin
                sdata_d  = trama_ini[15];
                trama_d  = {trama_ini[14:0], 1'b0};
                bits_d   = 4'd15;
                cnt_d    = '0;
                fase_d   = 1'b0;
                sync_n_d = 1'b0;
                sclk_d   = 1'b1;
                saturo_d = saturo_q | clip;
                state_d  = TX;
            end
            TX: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (!fase_q) begin
                        sclk_d = 1'b0;
                        fase_d = 1'b1;
                    end else if (bits_q == 4'd0) begin
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        sdata_d  = 1'b0;
                        state_d  = FIN;
                    end else begin
                        // New bit goes out with the rising edge, held across the falling one.
                        sclk_d  = 1'b1;
                        fase_d  = 1'b0;
                        sdata_d = trama_q[15];
                        trama_d = {trama_q[14:0], 1'b0};
                        bits_d  = bits_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == FIN_PULSE) fin_tx_d = 1'b1;
                if (cnt_q == FIN_END) begin
                    cnt_d     = '0;
                    ocupado_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fase_q    <= 1'b0;
            bits_q    <= 4'd0;
            trama_q   <= 16'd0;
            muestra_q <= '0;
            sclk_q    <= 1'b1;
            sync_n_q  <= 1'b1;
            sdata_q   <= 1'b0;
            ocupado_q <= 1'b0;
            fin_tx_q  <= 1'b0;
            perdida_q <= 1'b0;
            saturo_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fase_q    <= fase_d;
            bits_q    <= bits_d;
            trama_q   <= trama_d;
            muestra_q <= muestra_d;
            sclk_q    <= sclk_d;
            sync_n_q  <= sync_n_d;
            sdata_q   <= sdata_d;
            ocupado_q <= ocupado_d;
            fin_tx_q  <= fin_tx_d;
            perdida_q <= perdida_d;
            saturo_q  <= saturo_d;
        end
    end

    assign sclk    = sclk_q;
    assign sync_n  = sync_n_q;
    assign sdata   = sdata_q;
    assign ocupado = ocupado_q;
    assign fin_tx  = fin_tx_q;
    assign perdida = perdida_q;
    assign saturo  = saturo_q;
endmodule

// File: tb/tb_serializador_dac.sv
// Bench for serializador_dac: cycle-timeline model of the frame plus
// directed samples with hand-computed frames.
module tb_serializador_dac;
    localparam int DIV = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [21:0] dato_in;
    logic               dato_listo;
    logic sclk, sync_n, sdata, ocupado, fin_tx, perdida, saturo;

    int nvec = 0;
    int nerr = 0;

    serializador_dac #(.width(22), .shift(8), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .dato_in(dato_in), .dato_listo(dato_listo),
        .sclk(sclk), .sync_n(sync_n), .sdata(sdata), .ocupado(ocupado),
        .fin_tx(fin_tx), .perdida(perdida), .saturo(saturo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: timeline relative to the accept edge, k = cycles since accept.
    bit        m_busy = 0;
    int        m_k = 0;
    bit        m_perd = 0, m_sat = 0, m_clip = 0;
    bit [15:0] m_frame = 0;
    int        cnt_sync = 0, cnt_ocup = 0, cnt_fin = 0;
    logic [15:0] rx = 0, last_frame = 0;
    logic      prev_sclk = 1'b1, prev_sync = 1'b1;

    always @(posedge clk) begin
        bit       busy_b;
        int       v, sv;
        bit [6:0] exp_o;
        busy_b = m_busy;
        if (!reset) begin
            m_busy = 0; m_k = 0; m_perd = 0; m_sat = 0;
        end else begin
            if (m_busy) begin
                m_k++;
                if (m_k == 1) m_sat = m_sat | m_clip;
                if (m_k > 34 * DIV) m_busy = 0;
            end
            if (dato_listo) begin
                if (!busy_b) begin
                    v = int'(dato_in);
                    sv = v >>> 8;
                    m_clip = 0;
`ifdef SATURACION_EN
                    if (sv > 2047) begin sv = 2047; m_clip = 1; end
                    if (sv < -2048) begin sv = -2048; m_clip = 1; end
`endif
                    m_frame = 16'((sv + 2048) & 32'hFFF);
                    m_busy = 1;
                    m_k = 0;
                end else begin
                    m_perd = 1;
                end
            end
        end
        // {sclk, sync_n, sdata, ocupado, fin_tx, perdida, saturo}
        exp_o = {1'b1, 1'b1, 1'b0, m_busy, 1'b0, m_perd, m_sat};
        if (m_busy && m_k >= 1 && m_k <= 32 * DIV) begin
            exp_o[6] = ((m_k - 1) % (2 * DIV)) < DIV;
            exp_o[5] = 1'b0;
            exp_o[4] = m_frame[15 - (m_k - 1) / (2 * DIV)];
        end
        if (m_busy && m_k == 34 * DIV) exp_o[2] = 1'b1;
        #1;
        chk("cycle", {25'd0, sclk, sync_n, sdata, ocupado, fin_tx, perdida, saturo},
            {25'd0, exp_o});
        // Receiver side: what an external DAC would latch on falling sclk.
        if (prev_sync && !sync_n) rx = 16'd0;
        if (prev_sclk && !sclk && !sync_n) rx = {rx[14:0], sdata};
        if (!prev_sync && sync_n) last_frame = rx;
        if (!sync_n) cnt_sync++;
        if (ocupado) cnt_ocup++;
        if (fin_tx) cnt_fin++;
        prev_sclk = sclk;
        prev_sync = sync_n;
    end

    task automatic strobe(input int v);
        @(negedge clk);
        dato_in = 22'(v);
        dato_listo = 1'b1;
        @(negedge clk);
        dato_listo = 1'b0;
    endtask

    task automatic wait_fin();
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (fin_tx === 1'b1) seen = 1;
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL fin_timeout: fin_tx not seen within 300 cycles");
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        int b_sync, b_ocup, b_fin;
        reset = 1'b0;
        dato_listo = 1'b0;
        dato_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {25'd0, sclk, sync_n, sdata, ocupado, fin_tx, perdida, saturo},
            {25'd0, 7'b1100000});
        reset = 1'b1;

        // Zero sample: mid-scale code and frame timing
        b_sync = cnt_sync; b_ocup = cnt_ocup; b_fin = cnt_fin;
        strobe(0);
        wait_fin();
        chk("frame_zero", 32'(last_frame), 32'h0800);
        chk("sync_low_cycles", 32'(cnt_sync - b_sync), 32'd64);
        chk("ocupado_cycles", 32'(cnt_ocup - b_ocup), 32'd69);
        chk("fin_count", 32'(cnt_fin - b_fin), 32'd1);
        repeat (3) @(negedge clk);

        strobe(256000);
        wait_fin();
        chk("frame_1000", 32'(last_frame), 32'h0BE8);
        chk("saturo_1000", 32'(saturo), 32'd0);
        repeat (2) @(negedge clk);

        strobe(2097151);
        wait_fin();
`ifdef SATURACION_EN
        chk("frame_posmax", 32'(last_frame), 32'h0FFF);
        chk("saturo_posmax", 32'(saturo), 32'd1);
`else
        chk("frame_posmax", 32'(last_frame), 32'h07FF);
        chk("saturo_posmax", 32'(saturo), 32'd0);
`endif
        chk("perdida_clean", 32'(perdida), 32'd0);

        pulse_reset();
        strobe(-2097152);
        wait_fin();
`ifdef SATURACION_EN
        chk("frame_negmin", 32'(last_frame), 32'h0000);
        chk("saturo_negmin", 32'(saturo), 32'd1);
`else
        chk("frame_negmin", 32'(last_frame), 32'h0800);
        chk("saturo_negmin", 32'(saturo), 32'd0);
`endif

        // Strobe during a frame is dropped; the frame in flight is untouched.
        pulse_reset();
        strobe(-256000);
        repeat (8) @(negedge clk);
        strobe(256000);
        wait_fin();
        chk("frame_kept", 32'(last_frame), 32'h0418);
        chk("perdida_set", 32'(perdida), 32'd1);
        @(posedge clk);
        @(negedge clk);
        dato_in = 22'(256000);
        dato_listo = 1'b1;
        @(posedge clk); #2;
        chk("accept_after_fin", {30'd0, ocupado, sync_n}, {30'd0, 2'b11});
        @(negedge clk);
        dato_listo = 1'b0;
        @(posedge clk); #2;
        chk("sync_falls_next", 32'(sync_n), 32'd0);
        wait_fin();
        chk("frame_back2back", 32'(last_frame), 32'h0BE8);

        // Reset lands in the middle of bit 7.
        repeat (2) @(negedge clk);
        strobe(256000);
        repeat (34) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #2;
        chk("abort_state", {25'd0, sclk, sync_n, sdata, ocupado, fin_tx, perdida, saturo},
            {25'd0, 7'b1100000});
        @(negedge clk);
        reset = 1'b1;
        strobe(5000);
        wait_fin();
        chk("frame_after_abort", 32'(last_frame), 32'h0813);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
